// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, frame constants and sizing helpers.
// The PARITY state is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DATA_W    = 8;
  localparam int UART_STOP_BITS = 1;

  function automatic int uart_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Cycles from the start-bit edge to the end of the stop bit.
  function automatic int uart_frame_len(input int baud_div, input bit parity_en);
    return baud_div * (1 + UART_DATA_W + (parity_en ? 1 : 0) + UART_STOP_BITS);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with wrap-around pointers and an occupancy count.
// Shared between the UART transmitter and the planned receiver.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic [uart_clog2(DEPTH):0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int PTR_W = uart_clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser (8E1 when UART_TX_PARITY_EN is defined).
// TX is registered and idles high; consecutive frames are sent with no idle gap.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 87,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           SYSCLK,
  input  logic                           NSYSRESET,
  input  logic [7:0]                     TX_DATA,
  input  logic                           TX_VALID,
  output logic                           TX_READY,
  output logic                           TX,
  output logic                           BUSY,
  output logic [uart_clog2(FIFO_DEPTH):0] FIFO_COUNT
);

  localparam int              CNT_W     = uart_clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_W - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic                            fifo_push;
  logic                            fifo_pop;
  logic [7:0]                      fifo_rdata;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [uart_clog2(FIFO_DEPTH):0] fifo_count;
  logic                            bit_done;

  assign TX_READY   = !fifo_full && NSYSRESET;
  assign fifo_push  = TX_VALID && TX_READY;
  assign bit_done   = (baud_cnt_q == BAUD_LAST);
  assign TX         = tx_q;
  assign FIFO_COUNT = fifo_count;
  assign BUSY       = (state_q != IDLE) || (fifo_count != '0);

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (SYSCLK),
    .rst_n (NSYSRESET),
    .push  (fifo_push),
    .wdata (TX_DATA),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != IDLE) baud_cnt_d = bit_done ? '0 : baud_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_rdata;
`endif
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        // A queued byte goes straight into its start bit, keeping frames back to back.
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_rdata;
`endif
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (!NSYSRESET) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer (BAUD_DIV=4, FIFO_DEPTH=4); honours UART_TX_PARITY_EN.
// A frame-level model predicts TX, BUSY, FIFO_COUNT and TX_READY after every clock edge.
module tb_uart_tx_serializer;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = BAUD * NBITS;
  // Edge index at which the table's 0x55 frame starts (accepted on edge 4).
  localparam int VEC_START_EDGE = 5;

  logic       sysclk = 1'b0;
  logic       nsysreset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;
  int edge_t = 0;

  // Model: every byte accepted since the last reset with the edge its start bit begins.
  logic [7:0] m_data[$];
  int         m_st[$];

  typedef struct {
    logic       rstn;
    logic       valid;
    logic [7:0] data;
    logic       exp_tx;
    logic       exp_busy;
    int         exp_count;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[9];

  always #5 sysclk = ~sysclk;

  uart_tx_serializer #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .SYSCLK     (sysclk),
    .NSYSRESET  (nsysreset),
    .TX_DATA    (tx_data),
    .TX_VALID   (tx_valid),
    .TX_READY   (tx_ready),
    .TX         (tx),
    .BUSY       (busy),
    .FIFO_COUNT (fifo_count)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at edge %0d", edge_t);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_t);
    end
  endtask

  function automatic int popsBy(input int e);
    int n;
    n = 0;
    foreach (m_st[i]) if (m_st[i] <= e) n++;
    return n;
  endfunction

  function automatic logic inFlight(input int e);
    foreach (m_st[i]) if (e >= m_st[i] && e < m_st[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  // Line level after edge e: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic expTx(input int e);
    foreach (m_st[i]) begin
      if (e >= m_st[i] && e < m_st[i] + FRAME) begin
        int k;
        k = (e - m_st[i]) / BAUD;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_data[i][k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^m_data[i];
`endif
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  // A byte's start bit begins one edge after acceptance or when the previous frame ends.
  task automatic modelEdge(input logic rstn, input logic valid, input logic [7:0] data);
    int occ_before;
    int s;
    edge_t++;
    if (!rstn) begin
      m_data.delete();
      m_st.delete();
    end else begin
      occ_before = m_data.size() - popsBy(edge_t - 1);
      if (valid && occ_before < DEPTH) begin
        s = edge_t + 1;
        if (m_st.size() > 0 && m_st[m_st.size()-1] + FRAME > s) s = m_st[m_st.size()-1] + FRAME;
        m_data.push_back(data);
        m_st.push_back(s);
      end
    end
  endtask

  task automatic checkOutput();
    int occ;
    occ = m_data.size() - popsBy(edge_t);
    checkEq("model_tx", tx, expTx(edge_t));
    checkEq("model_busy", busy, inFlight(edge_t) || occ > 0);
    checkEq("model_count", fifo_count, occ);
    checkEq("model_ready", tx_ready, nsysreset && occ < DEPTH);
  endtask

  task automatic applyStimulus(input logic rstn, input logic valid, input logic [7:0] data);
    nsysreset = rstn;
    tx_valid  = valid;
    tx_data   = data;
    @(posedge sysclk);
    modelEdge(rstn, valid, data);
    @(negedge sysclk);
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 600) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      guard++;
    end
    checkEq("drain_idle", busy, 0);
    idleCycles(2);
  endtask

  // Decodes one frame by sampling the middle of each bit period.
  task automatic recvByte(output logic [7:0] b, output int s);
    int guard;
    guard = 0;
    b = 8'h00;
    s = -1;
    while (tx !== 1'b0 && guard < 400) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      guard++;
    end
    checkEq("rx_start_found", tx === 1'b0, 1);
    if (tx !== 1'b0) return;
    s = edge_t;
    idleCycles(2);
    checkEq("rx_start_bit", tx, 0);
    for (int i = 0; i < 8; i++) begin
      idleCycles(BAUD);
      b[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    idleCycles(BAUD);
    checkEq("rx_parity_bit", tx, ^b);
`endif
    idleCycles(BAUD);
    checkEq("rx_stop_bit", tx, 1);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic measureParityFrame(input logic [7:0] data, input logic exp_par);
    int acc;
    int guard;
    logic par;
    par = 1'bx;
    applyStimulus(1'b1, 1'b1, data);
    acc = edge_t;
    guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      if (edge_t == acc + 1 + BAUD * 9 + 2) par = tx;
      guard++;
    end
    checkEq("par_frame_len", edge_t - acc - 1, 44);
    checkEq("par_bit", par, exp_par);
    idleCycles(2);
  endtask
`endif

  initial begin
    logic [7:0] b1, b2;
    int s1, s2;
    int acc;
    int j, guard, lows;
    int acc_e[6];
    logic r;

    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].valid, vecs[i].data);
      checkEq($sformatf("vec%0d_tx", i), tx, vecs[i].exp_tx);
      checkEq($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      checkEq($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_count);
      checkEq($sformatf("vec%0d_ready", i), tx_ready, vecs[i].exp_ready);
    end

    // BUSY stays high for exactly one frame after the start bit.
    while (edge_t < VEC_START_EDGE + FRAME - 1) applyStimulus(1'b1, 1'b0, 8'h00);
    checkEq("single_busy_last", busy, 1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkEq("single_busy_drop", busy, 0);
    idleCycles(3);

    // Back-to-back: second push lands on the first byte's pop edge.
    applyStimulus(1'b1, 1'b1, 8'hA3);
    applyStimulus(1'b1, 1'b1, 8'h0F);
    checkEq("pushpop_count", fifo_count, 1);
    recvByte(b1, s1);
    recvByte(b2, s2);
    checkEq("b2b_byte0", b1, 8'hA3);
    checkEq("b2b_byte1", b2, 8'h0F);
    checkEq("b2b_spacing", s2 - s1, FRAME);
    drain();

`ifdef UART_TX_PARITY_EN
    measureParityFrame(8'h07, 1'b1);
    measureParityFrame(8'h03, 1'b0);
`endif

    // FIFO full: hold TX_VALID across bytes 0x01..0x06.
    j = 0;
    guard = 0;
    while (j < 6 && guard < 500) begin
      r = tx_ready;
      applyStimulus(1'b1, 1'b1, 8'(j + 1));
      if (r === 1'b1) begin
        acc_e[j] = edge_t;
        j++;
        if (j == 5) begin
          checkEq("full_count", fifo_count, 4);
          checkEq("full_ready", tx_ready, 0);
        end
      end
      guard++;
    end
    checkEq("full_accepted", j, 6);
    if (j == 6) begin
      checkEq("full_fifth_edge", acc_e[4] - acc_e[0], 4);
      checkEq("full_sixth_edge", acc_e[5] - acc_e[0], FRAME + 2);
    end
    drain();

    // Reset during DATA bit 3 with two bytes still queued.
    applyStimulus(1'b1, 1'b1, 8'h11);
    acc = edge_t;
    applyStimulus(1'b1, 1'b1, 8'h22);
    applyStimulus(1'b1, 1'b1, 8'h33);
    checkEq("rst_pre_count", fifo_count, 2);
    while (edge_t < acc + 1 + BAUD * 4 + 1) applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkEq("rst_tx", tx, 1);
    checkEq("rst_count", fifo_count, 0);
    checkEq("rst_busy", busy, 0);
    checkEq("rst_ready", tx_ready, 0);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      if (tx !== 1'b1) lows++;
    end
    checkEq("rst_quiet_lows", lows, 0);

    // Random traffic with occasional resets against the frame model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 249) != 0, $urandom_range(0, 2) == 0, 8'($urandom));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
